// File: rtl/real_div.sv
// real_div: iterative IEEE754 divider, radix-2 restoring, one quotient bit per cycle.
// Truncating by default; define REAL_DIV_RNE_EN for round-to-nearest-even.
module real_div #(
   parameter int EXP_W  = 11,
   parameter int MANT_W = 52,
   parameter int WIDTH  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [4:0]       flags
);
   localparam int EW = EXP_W + 2;
   localparam int QW = MANT_W + 3;
   localparam int RW = MANT_W + 2;
   localparam int CW = $clog2(QW + 1);
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EOVF = {2'b00, EMAX};
   localparam logic signed [EW-1:0] EZERO = '0;
   localparam logic [WIDTH-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};

   if (WIDTH != 1 + EXP_W + MANT_W) begin : g_bad_width
      $error("real_div: WIDTH must equal 1+EXP_W+MANT_W");
   end

   typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, DONE} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
   logic [4:0]             flags_q, flags_d;
   logic                   sign_q, sign_d, spec_q, spec_d;
   logic [RW-1:0]          rem_q, rem_d;
   logic [MANT_W:0]        mb_q, mb_d;
   logic [QW-1:0]          q_q, q_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic signed [EW-1:0]   e_q, e_d;

   logic [EXP_W-1:0]       ea, eb;
   logic [MANT_W-1:0]      fa, fb;
   logic                   za, zb, ia, ib, na, nb, sgn;
   logic                   ge;
   logic [RW-1:0]          diff;
   logic                   top, g, s, carry, ovf, unf;
   logic [MANT_W-1:0]      frac_n, frac_r;
   logic signed [EW-1:0]   e_n, e_r;

   assign ea  = a_q[WIDTH-2 -: EXP_W];
   assign eb  = b_q[WIDTH-2 -: EXP_W];
   assign fa  = a_q[MANT_W-1:0];
   assign fb  = b_q[MANT_W-1:0];
   assign za  = ea == '0;
   assign zb  = eb == '0;
   assign ia  = ea == EMAX && fa == '0;
   assign ib  = eb == EMAX && fb == '0;
   assign na  = ea == EMAX && fa != '0;
   assign nb  = eb == EMAX && fb != '0;
   assign sgn = a_q[WIDTH-1] ^ b_q[WIDTH-1];

   assign ge   = rem_q >= {1'b0, mb_q};
   assign diff = ge ? rem_q - {1'b0, mb_q} : rem_q;

   // Quotient is in [0.5, 2): a clear top bit means one extra normalising shift.
   assign top    = q_q[QW-1];
   assign frac_n = top ? q_q[QW-2:2] : q_q[QW-3:1];
   assign g      = top ? q_q[1] : q_q[0];
   assign s      = (top & q_q[0]) | (rem_q != '0);
   assign e_n    = top ? e_q : e_q - EW'(1);
`ifdef REAL_DIV_RNE_EN
   assign {carry, frac_r} = {1'b0, frac_n} + {{MANT_W{1'b0}}, g & (s | frac_n[0])};
`else
   assign carry  = 1'b0;
   assign frac_r = frac_n;
`endif
   assign e_r = e_n + EW'(carry);
   assign ovf = e_r >= EOVF;
   assign unf = e_r <= EZERO;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      flags_d = flags_q;
      sign_d  = sign_q;
      spec_d  = spec_q;
      rem_d   = rem_q;
      mb_d    = mb_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = op_a;
            b_d     = op_b;
            state_d = UNPACK;
         end
         UNPACK: begin
            sign_d  = sgn;
            spec_d  = 1'b1;
            state_d = NORM;
            flags_d = '0;
            if (na | nb | (za & zb) | (ia & ib)) begin
               res_d   = QNAN;
               flags_d = 5'b10000;
            end else if (ia) begin
               res_d = {sgn, EMAX, {MANT_W{1'b0}}};
            end else if (zb) begin
               res_d   = {sgn, EMAX, {MANT_W{1'b0}}};
               flags_d = 5'b01000;
            end else if (za | ib) begin
               res_d = {sgn, {(WIDTH-1){1'b0}}};
            end else begin
               spec_d  = 1'b0;
               state_d = DIVIDE;
               rem_d   = {2'b01, fa};
               mb_d    = {1'b1, fb};
               q_d     = '0;
               cnt_d   = CW'(QW);
               e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
            end
         end
         DIVIDE: begin
            rem_d = diff << 1;
            q_d   = {q_q[QW-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = NORM;
         end
         // Specials also pass through here so both paths share the DONE entry.
         NORM: begin
            state_d = DONE;
            if (!spec_q) begin
               res_d   = ovf ? {sign_q, EMAX, {MANT_W{1'b0}}} :
                         unf ? {sign_q, {(WIDTH-1){1'b0}}} :
                               {sign_q, e_r[EXP_W-1:0], frac_r};
               flags_d = ovf ? 5'b00101 : unf ? 5'b00011 : {4'b0000, g | s};
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         res_q   <= '0;
         flags_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         spec_q  <= 1'b0;
         rem_q   <= '0;
         mb_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         spec_q  <= spec_d;
         rem_q   <= rem_d;
         mb_q    <= mb_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
      end
   end

   assign in_ready  = state_q == IDLE && !reset;
   assign out_valid = state_q == DONE;
   assign res       = res_q;
   assign flags     = flags_q;
endmodule

// File: tb/tb_real_div.sv
// tb_real_div: directed vector table plus backpressure and mid-operation reset sequences.
module tb_real_div;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] op_a = '0, op_b = '0;
   logic        in_ready, out_valid;
   logic [63:0] res;
   logic [4:0]  flags;

   int checks = 0;
   int failures = 0;

   real_div dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic [4:0]  f;
      int          lat;
   } vec_t;

   vec_t v[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic run(input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] r, output logic [4:0] f, output int lat);
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a = ~a;
      op_b = ~b;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      r = res;
      f = flags;
   endtask

   logic [63:0] r;
   logic [4:0]  f;
   int          lat;
   bit          seen;

   initial begin
      v[0]  = '{64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 57};
`ifdef REAL_DIV_RNE_EN
      v[1]  = '{64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB999999999999A, 5'b00001, 57};
`else
      v[1]  = '{64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB9999999999999, 5'b00001, 57};
`endif
      v[2]  = '{64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b01000, 2};
      v[3]  = '{64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b10000, 2};
      v[4]  = '{64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101, 57};
      v[5]  = '{64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011, 57};
      v[6]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b10000, 2};
      v[7]  = '{64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'b10000, 2};
      v[8]  = '{64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 5'b00000, 2};
      v[9]  = '{64'h4008000000000000, 64'hFFF0000000000000, 64'h8000000000000000, 5'b00000, 2};
      v[10] = '{64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 5'b00000, 2};
      v[11] = '{64'hBFF8000000000000, 64'h3FE0000000000000, 64'hC008000000000000, 5'b00000, 57};
      v[12] = '{64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001, 57};
      v[13] = '{64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 5'b00000, 2};
      v[14] = '{64'h3FF0000000000000, 64'h0000000000000001, 64'h7FF0000000000000, 5'b01000, 2};

      repeat (3) @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_res", res, 64'd0);
      chk("reset_flags", 64'(flags), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 15; i++) begin
         run(v[i].a, v[i].b, r, f, lat);
         chk($sformatf("vec%0d_res", i), r, v[i].r);
         chk($sformatf("vec%0d_flags", i), 64'(f), 64'(v[i].f));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v[i].lat));
         out_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_drop", i), 64'(out_valid), 64'd0);
         out_ready = 1'b0;
      end

      run(64'h4018000000000000, 64'h4000000000000000, r, f, lat);
      chk("bp_latency", 64'(lat), 64'd57);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_res", res, 64'h4008000000000000);
         chk("bp_flags", 64'(flags), 64'd0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b0;

      op_a = 64'h4018000000000000;
      op_b = 64'h4000000000000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_res", res, 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst_no_stale_result", 64'(seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
